// File: rtl/fir_folded_mac_sched_if.sv
// Sample, coefficient-programming and result signals of the folded FIR MAC scheduler.
// slave is the scheduler side, master is the driving side.
interface fir_folded_mac_sched_if #(
  parameter int unsigned NB_INPUT  = 16,
  parameter int unsigned NB_OUTPUT = 18,
  parameter int unsigned NB_COEF   = 16,
  parameter int unsigned N_TAPS    = 4
);
  // One extra address bit so out-of-range coefficient indices are representable.
  localparam int unsigned AddrW = $clog2(N_TAPS / 2) + 1;

  logic                 i_valid;
  logic [NB_INPUT-1:0]  i_data;
  logic                 o_ready;
  logic                 i_clear;
  logic                 i_coef_we;
  logic [AddrW-1:0]     i_coef_addr;
  logic [NB_COEF-1:0]   i_coef_data;
  logic                 o_coef_err;
  logic                 o_valid;
  logic [NB_OUTPUT-1:0] o_data;

  modport slave (
    input  i_valid, i_data, i_clear, i_coef_we, i_coef_addr, i_coef_data,
    output o_ready, o_coef_err, o_valid, o_data
  );

  modport master (
    output i_valid, i_data, i_clear, i_coef_we, i_coef_addr, i_coef_data,
    input  o_ready, o_coef_err, o_valid, o_data
  );
endinterface

// File: rtl/fir_folded_mac_sched.sv
// Folded symmetric FIR: one pre-adder, multiplier and saturating rounder shared across
// the N_TAPS/2 tap pairs, one pair per cycle, sequenced by a two-state FSM.
module fir_folded_mac_sched #(
  parameter int unsigned NB_INPUT  = 16,
  parameter int unsigned NB_OUTPUT = 18,
  parameter int unsigned NB_COEF   = 16,
  parameter int unsigned N_TAPS    = 4
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  fir_folded_mac_sched_if.slave   bus
);
  localparam int unsigned NPairs = N_TAPS / 2;
  localparam int unsigned AddrW  = $clog2(NPairs) + 1;
  localparam int unsigned KW     = $clog2(NPairs);
  localparam int unsigned XIdxW  = $clog2(N_TAPS);
  localparam int unsigned NbSum  = NB_INPUT + 1;
  localparam int unsigned NbProd = NbSum + NB_COEF;
  localparam int unsigned NbPrw  = NbProd + 1;
  localparam int unsigned NbRnd  = NB_INPUT + 1;
  localparam int unsigned NbAcc  = NbRnd + $clog2(NPairs);
  localparam int unsigned NbWide = NbAcc + NB_OUTPUT;

  localparam logic signed [NbPrw-1:0] RndHalf = NbPrw'(64'sd1 <<< (NB_COEF - 2));
  localparam logic signed [NbPrw-1:0] RndMax  = NbPrw'((64'sd1 <<< (NbRnd - 1)) - 64'sd1);
  localparam logic signed [NbPrw-1:0] RndMin  = -RndMax - NbPrw'(1);
  localparam logic signed [NbWide-1:0] OutMax = NbWide'((64'sd1 <<< (NB_OUTPUT - 1)) - 64'sd1);
  localparam logic signed [NbWide-1:0] OutMin = -OutMax - NbWide'(1);

  typedef enum logic [0:0] {StIdle, StMac} state_e;

  state_e                      state_q;
  logic [KW-1:0]               k_q;
  logic signed [NB_INPUT-1:0]  x_q    [N_TAPS];
  logic signed [NB_COEF-1:0]   coef_q [NPairs];
  logic signed [NbAcc-1:0]     acc_q;
  logic [NB_OUTPUT-1:0]        o_data_q;
  logic                        o_valid_q;
  logic                        coef_err_q;

  logic [XIdxW-1:0]            lo_idx, hi_idx;
  logic signed [NB_INPUT-1:0]  x_lo, x_hi;
  logic signed [NbSum-1:0]     pair_sum;
  logic signed [NbProd-1:0]    prod;
  logic signed [NbPrw-1:0]     prod_rnd, prod_shift;
  logic signed [NbRnd-1:0]     rnd_sat;
  logic signed [NbAcc-1:0]     acc_next;
  logic signed [NbWide-1:0]    acc_wide;
  logic [NB_OUTPUT-1:0]        out_sat;
  logic                        coef_ok;

  always_comb begin
    lo_idx   = XIdxW'(k_q);
    hi_idx   = XIdxW'(N_TAPS - 1) - XIdxW'(k_q);
    x_lo     = x_q[lo_idx];
    x_hi     = x_q[hi_idx];
    pair_sum = NbSum'(x_lo) + NbSum'(x_hi);
    prod     = NbProd'(pair_sum) * NbProd'(coef_q[k_q]);
    // Round half up at the Q15 boundary, then clamp to the (17,15) range.
    prod_rnd   = NbPrw'(prod) + RndHalf;
    prod_shift = prod_rnd >>> (NB_COEF - 1);
    if (prod_shift > RndMax)      rnd_sat = RndMax[NbRnd-1:0];
    else if (prod_shift < RndMin) rnd_sat = RndMin[NbRnd-1:0];
    else                          rnd_sat = prod_shift[NbRnd-1:0];
    acc_next = acc_q + NbAcc'(rnd_sat);
    acc_wide = NbWide'(acc_next);
    if (acc_wide > OutMax)      out_sat = OutMax[NB_OUTPUT-1:0];
    else if (acc_wide < OutMin) out_sat = OutMin[NB_OUTPUT-1:0];
    else                        out_sat = acc_wide[NB_OUTPUT-1:0];
  end

  assign coef_ok = (state_q == StIdle) && (bus.i_coef_addr < AddrW'(NPairs));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      acc_q      <= '0;
      o_data_q   <= '0;
      o_valid_q  <= 1'b0;
      coef_err_q <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) x_q[i] <= '0;
      for (int i = 0; i < NPairs; i++) coef_q[i] <= '0;
    end else begin
      o_valid_q  <= 1'b0;
      coef_err_q <= 1'b0;
      if (bus.i_coef_we) begin
        if (coef_ok) coef_q[bus.i_coef_addr[KW-1:0]] <= $signed(bus.i_coef_data);
        else         coef_err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.i_clear) begin
            for (int i = 0; i < N_TAPS; i++) x_q[i] <= '0;
          end else if (bus.i_valid) begin
            x_q[0] <= $signed(bus.i_data);
            for (int i = 1; i < N_TAPS; i++) x_q[i] <= x_q[i-1];
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_next;
          if (k_q == KW'(NPairs - 1)) begin
            o_data_q  <= out_sat;
            o_valid_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_ready    = (state_q == StIdle) && !bus.i_clear && i_rst_n;
  assign bus.o_valid    = o_valid_q;
  assign bus.o_data     = o_data_q;
  assign bus.o_coef_err = coef_err_q;
endmodule

// File: tb/tb_fir_folded_mac_sched.sv
// Directed bench for fir_folded_mac_sched: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares value and arrival cycle on every o_valid.
module tb_fir_folded_mac_sched;
  localparam int unsigned NbIn   = 16;
  localparam int unsigned NbOut  = 18;
  localparam int unsigned NbCoef = 16;
  localparam int unsigned NTaps  = 4;
  localparam int unsigned AddrW  = $clog2(NTaps / 2) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_acc = 0;

  logic [NbOut-1:0] exp_q [$];
  int               exp_cyc_q [$];
  logic [NbOut-1:0] mon_e;
  int               mon_c;

  fir_folded_mac_sched_if #(
    .NB_INPUT (NbIn),
    .NB_OUTPUT(NbOut),
    .NB_COEF  (NbCoef),
    .N_TAPS   (NTaps)
  ) bus ();

  fir_folded_mac_sched #(
    .NB_INPUT (NbIn),
    .NB_OUTPUT(NbOut),
    .NB_COEF  (NbCoef),
    .N_TAPS   (NTaps)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every o_valid must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: got o_data 0x%0h with no result expected", bus.o_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if (bus.o_data !== mon_e || cyc != mon_c) begin
          failures++;
          $display("FAIL result: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                   bus.o_data, cyc, mon_e, mon_c);
        end
      end
    end
  end

  // exp_wait < 0 skips the handshake-spacing checks.
  task automatic send(input logic [NbIn-1:0] d, input logic [NbOut-1:0] e, input int exp_wait);
    int waited = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    @(negedge clk);
    while (bus.o_ready !== 1'b1 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (bus.o_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got o_ready 0 for %0d cycles expected 1", waited);
      bus.i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 2);
    if (exp_wait >= 0) begin
      chk("ready_low_cycles", 32'(waited), 32'(exp_wait));
      chk("accept_spacing", 32'(cyc - last_acc), 32'd3);
    end
    last_acc = cyc;
  endtask

  task automatic write_coef(input logic [AddrW-1:0] a, input logic [NbCoef-1:0] d,
                            input logic exp_err);
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = a;
    bus.i_coef_data = d;
    @(posedge clk);
    #1;
    bus.i_coef_we = 1'b0;
    chk("coef_err", 32'(bus.o_coef_err), 32'(exp_err));
  endtask

  task automatic clear_line();
    bus.i_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.i_clear = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid     = 1'b0;
    bus.i_data      = '0;
    bus.i_clear     = 1'b0;
    bus.i_coef_we   = 1'b0;
    bus.i_coef_addr = '0;
    bus.i_coef_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(bus.o_ready), 32'd1);
    chk("reset_valid", 32'(bus.o_valid), 32'd0);
    chk("reset_data", 32'(bus.o_data), 32'd0);
    chk("reset_coef_err", 32'(bus.o_coef_err), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-MAC: the accepted sample is aborted, nothing is produced.
    write_coef(2'd0, 16'h4000, 1'b0);
    write_coef(2'd1, 16'h2000, 1'b0);
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h4000;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", 32'(bus.o_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_ready", 32'(bus.o_ready), 32'd1);
    chk("abort_data", 32'(bus.o_data), 32'd0);
    @(posedge clk);
    #1;
    // Bank was zeroed by reset.
    send(16'h4000, 18'h00000, -1);
    drain();
    clear_line();

    // Impulse response, back-to-back after the first sample.
    write_coef(2'd0, 16'h4000, 1'b0);
    write_coef(2'd1, 16'h2000, 1'b0);
    send(16'h4000, 18'h02000, -1);
    send(16'h0000, 18'h01000, 2);
    send(16'h0000, 18'h01000, 2);
    send(16'h0000, 18'h02000, 2);
    send(16'h0000, 18'h00000, 2);
    drain();

    // Clear beats valid in IDLE; next impulse sees an empty history.
    send(16'h7FFF, 18'h04000, -1);
    send(16'h7FFF, 18'h06000, 2);
    drain();
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h1234;
    bus.i_clear = 1'b1;
    @(negedge clk);
    chk("ready_during_clear", 32'(bus.o_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_clear = 1'b0;
    send(16'h4000, 18'h02000, -1);
    send(16'h0000, 18'h01000, 2);
    drain();

    // Rounding of half an LSB.
    write_coef(2'd0, 16'h0001, 1'b0);
    write_coef(2'd1, 16'h0000, 1'b0);
    clear_line();
    send(16'h4000, 18'h00001, -1);
    drain();
    clear_line();
    send(16'hC000, 18'h00000, -1);
    drain();

    // Saturation of each pair product.
    write_coef(2'd0, 16'h8000, 1'b0);
    write_coef(2'd1, 16'h8000, 1'b0);
    clear_line();
    send(16'h8000, 18'h08000, -1);
    send(16'h8000, 18'h10000, 2);
    send(16'h8000, 18'h17FFF, 2);
    send(16'h8000, 18'h1FFFE, 2);
    drain();

    // Rejected writes leave the bank untouched.
    write_coef(2'd0, 16'h4000, 1'b0);
    write_coef(2'd1, 16'h2000, 1'b0);
    clear_line();
    send(16'h4000, 18'h02000, -1);
    write_coef(2'd0, 16'h7FFF, 1'b1);
    drain();
    write_coef(2'd2, 16'h7FFF, 1'b1);
    send(16'h0000, 18'h01000, -1);
    send(16'h0000, 18'h01000, 2);
    send(16'h0000, 18'h02000, 2);
    send(16'h0000, 18'h00000, 2);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
